// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package seq_addsub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

   // Width of the chunk index counter; never narrower than one bit, even when N == K.
   function automatic int idx_width(input int n, input int k);
      int w;
      w = $clog2(n / k);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_addsub_slice.sv
// K-bit ripple slice: sum, carry out, and the carry into the slice MSB.
module addsub_slice #(
   parameter int K = 8
) (
   input  logic [K-1:0] x,
   input  logic [K-1:0] y,
   input  logic         cin,
   output logic [K-1:0] s,
   output logic         cout,
   output logic         cmsb
);
   logic [K:0] total;

   assign total = {1'b0, x} + {1'b0, y} + {{K{1'b0}}, cin};
   assign s     = total[K-1:0];
   assign cout  = total[K];
   // MSB sum bit is x ^ y ^ carry-in, so the carry into the MSB is recovered by XOR.
   assign cmsb  = s[K-1] ^ x[K-1] ^ y[K-1];

endmodule

// File: rtl/seq_addsub.sv
// N-bit add/subtract computed K bits per clock with a registered ripple carry.
//
// state | meaning
// IDLE  | waiting for start; sum/cout/ovf hold the last result
// RUN   | one chunk per cycle, idx selects the chunk, carry held in carry_q
// DONE  | done pulse; a start here is accepted straight into RUN
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   localparam int C  = N / K;
   localparam int IW = idx_width(N, K);
   localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);

   addsub_state_t state_q, state_d;
   logic [N-1:0]  op_a_q, op_b_q, sum_q;
   logic          carry_q, cout_q, ovf_q, busy_q, done_q;
   logic [IW-1:0] idx_q;
   logic          accept, last_chunk;
   logic [K-1:0]  slice_x, slice_y, slice_s;
   logic          slice_cout, slice_cmsb;

   assign accept     = start && (state_q != RUN);
   assign last_chunk = (idx_q == LAST_IDX);
   assign slice_x    = op_a_q[int'(idx_q) * K +: K];
   assign slice_y    = op_b_q[int'(idx_q) * K +: K];

   addsub_slice #(.K(K)) u_slice (
      .x    (slice_x),
      .y    (slice_y),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout),
      .cmsb (slice_cmsb)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         if (accept) begin
            // Subtract is a + ~b + 1: invert b once here and seed the carry with 1.
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
         end else if (state_q == RUN) begin
            sum_q[int'(idx_q) * K +: K] <= slice_s;
            carry_q <= slice_cout;
            idx_q   <= idx_q + IW'(1);
            if (last_chunk) begin
               cout_q <= slice_cout;
               ovf_q  <= slice_cmsb ^ slice_cout;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: four chunk widths side by side, checked each cycle against a timing/arithmetic model.
`timescale 1ns/1ps
module tb_seq_addsub;
   localparam int ND = 4;

   function automatic int k_of(input int g);
      case (g)
         0:       return 8;
         1:       return 1;
         2:       return 32;
         default: return 4;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v[ND], start_v[ND], sub_v[ND];
   logic [31:0] a_v[ND], b_v[ND], sum_v[ND];
   logic        busy_v[ND], done_v[ND], cout_v[ND], ovf_v[ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      seq_addsub #(.N(32), .K(k_of(g))) u_dut (
         .clk   (clk),
         .rst   (rst_v[g]),
         .start (start_v[g]),
         .sub   (sub_v[g]),
         .a     (a_v[g]),
         .b     (b_v[g]),
         .busy  (busy_v[g]),
         .done  (done_v[g]),
         .sum   (sum_v[g]),
         .cout  (cout_v[g]),
         .ovf   (ovf_v[g])
      );
   end

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model state: remaining RUN cycles, done pulse, visible result, pending result
   int          m_run[ND];
   bit          m_done[ND];
   logic [31:0] m_sum[ND], p_sum[ND];
   logic        m_cout[ND], m_ovf[ND], p_cout[ND], p_ovf[ND];

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d(K=%0d): actual %0h required %0h at %0t", nm, g, k_of(g), act, exp, $time);
      end
   endtask

   function automatic void ref_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                                  output logic [31:0] r, output logic co, output logic ov);
      logic [32:0] w;
      longint sr;
      w  = {1'b0, x} + {1'b0, y};
      r  = s ? (x - y) : (x + y);
      co = s ? (x >= y) : w[32];
      sr = s ? (longint'($signed(x)) - longint'($signed(y))) : (longint'($signed(x)) + longint'($signed(y)));
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   always @(negedge clk) begin
      logic [31:0] r;
      logic        co, ov;
      for (int g = 0; g < ND; g++) begin
         if (chk_en) begin
            chk("busy", g, {31'b0, busy_v[g]}, {31'b0, (m_run[g] > 0)});
            chk("done", g, {31'b0, done_v[g]}, {31'b0, m_done[g]});
            if (m_run[g] == 0) begin
               chk("sum", g, sum_v[g], m_sum[g]);
               chk("cout", g, {31'b0, cout_v[g]}, {31'b0, m_cout[g]});
               chk("ovf", g, {31'b0, ovf_v[g]}, {31'b0, m_ovf[g]});
            end
         end
         if (rst_v[g]) begin
            m_run[g]  = 0;
            m_done[g] = 1'b0;
            m_sum[g]  = '0;
            m_cout[g] = 1'b0;
            m_ovf[g]  = 1'b0;
         end else if (m_run[g] > 0) begin
            m_run[g]--;
            if (m_run[g] == 0) begin
               m_done[g] = 1'b1;
               m_sum[g]  = p_sum[g];
               m_cout[g] = p_cout[g];
               m_ovf[g]  = p_ovf[g];
            end
         end else begin
            m_done[g] = 1'b0;
            if (start_v[g]) begin
               m_run[g] = 32 / k_of(g);
               ref_op(a_v[g], b_v[g], sub_v[g], r, co, ov);
               p_sum[g]  = r;
               p_cout[g] = co;
               p_ovf[g]  = ov;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int g, input logic [31:0] x, input logic [31:0] y, input logic s,
                         input bit poke, output int lat);
      a_v[g] = x;
      b_v[g] = y;
      sub_v[g] = s;
      start_v[g] = 1'b1;
      tick();
      start_v[g] = 1'b0;
      lat = 0;
      while (1) begin
         if (lat >= 64) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout dut%0d: no done after %0d cycles", g, lat);
            break;
         end
         if (poke && busy_v[g]) begin
            start_v[g] = 1'($urandom_range(0, 1));
            a_v[g]     = $urandom;
            b_v[g]     = $urandom;
            sub_v[g]   = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
         if (done_v[g]) break;
      end
      start_v[g] = 1'b0;
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_ops(input int g, input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         run_op(g, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), 1'b1, lat);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, cnt, cyc, t_prev, nres;
      for (int g = 0; g < ND; g++) begin
         rst_v[g] = 1'b1;
         start_v[g] = 1'b0;
         sub_v[g] = 1'b0;
         a_v[g] = '0;
         b_v[g] = '0;
      end
      repeat (2) tick();
      chk_en = 1'b1;
      chk("reset_busy", 0, {31'b0, busy_v[0]}, 32'd0);
      chk("reset_done", 0, {31'b0, done_v[0]}, 32'd0);
      chk("reset_sum", 0, sum_v[0], 32'd0);
      for (int g = 0; g < ND; g++) rst_v[g] = 1'b0;
      tick();

      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      chk("carry_lat", 0, lat, 4);
      chk("carry_sum", 0, sum_v[0], 32'h0000_0000);
      chk("carry_cout", 0, {31'b0, cout_v[0]}, 32'd1);
      chk("carry_ovf", 0, {31'b0, ovf_v[0]}, 32'd0);

      run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      chk("sovf_sum", 0, sum_v[0], 32'h8000_0000);
      chk("sovf_cout", 0, {31'b0, cout_v[0]}, 32'd0);
      chk("sovf_ovf", 0, {31'b0, ovf_v[0]}, 32'd1);

      run_op(0, 32'd5, 32'd7, 1'b1, 1'b0, lat);
      chk("sub_sum", 0, sum_v[0], 32'hFFFF_FFFE);
      chk("sub_cout", 0, {31'b0, cout_v[0]}, 32'd0);
      chk("sub_ovf", 0, {31'b0, ovf_v[0]}, 32'd0);

      run_op(0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, lat);
      chk("subovf_sum", 0, sum_v[0], 32'h7FFF_FFFF);
      chk("subovf_cout", 0, {31'b0, cout_v[0]}, 32'd1);
      chk("subovf_ovf", 0, {31'b0, ovf_v[0]}, 32'd1);

      run_op(1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
      chk("k1_lat", 1, lat, 32);
      chk("k1_sum", 1, sum_v[1], 32'h8000_0000);
      run_op(2, 32'd5, 32'd7, 1'b1, 1'b0, lat);
      chk("k32_lat", 2, lat, 1);
      chk("k32_sum", 2, sum_v[2], 32'hFFFF_FFFE);
      run_op(3, 32'h8000_0000, 32'd1, 1'b1, 1'b0, lat);
      chk("k4_lat", 3, lat, 8);
      chk("k4_ovf", 3, {31'b0, ovf_v[3]}, 32'd1);

      // start while busy must be ignored
      a_v[0] = 32'h1234_5678;
      b_v[0] = 32'h1111_1111;
      sub_v[0] = 1'b0;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      a_v[0] = 32'd1;
      b_v[0] = 32'd1;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      cnt = 0;
      repeat (10) begin
         if (done_v[0]) begin
            cnt++;
            chk("busy_ign_sum", 0, sum_v[0], 32'h2345_6789);
         end
         tick();
      end
      chk("busy_ign_ndone", 0, cnt, 1);

      // start held high: results every C+1 cycles
      a_v[0] = 32'h0F0F_0F0F;
      b_v[0] = 32'h0101_0101;
      start_v[0] = 1'b1;
      cyc = 0;
      t_prev = -1;
      nres = 0;
      repeat (18) begin
         tick();
         cyc++;
         if (done_v[0]) begin
            if (t_prev >= 0) chk("b2b_gap", 0, cyc - t_prev, 5);
            t_prev = cyc;
            nres++;
            chk("b2b_sum", 0, sum_v[0], 32'h1010_1010);
         end
      end
      start_v[0] = 1'b0;
      chk("b2b_count", 0, nres, 3);
      repeat (8) tick();

      // reset during the second RUN cycle aborts the operation
      a_v[0] = 32'hFFFF_FFFF;
      b_v[0] = 32'hFFFF_FFFF;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      chk("abort_busy", 0, {31'b0, busy_v[0]}, 32'd0);
      chk("abort_done", 0, {31'b0, done_v[0]}, 32'd0);
      chk("abort_sum", 0, sum_v[0], 32'd0);
      chk("abort_cout", 0, {31'b0, cout_v[0]}, 32'd0);
      chk("abort_ovf", 0, {31'b0, ovf_v[0]}, 32'd0);
      cnt = 0;
      repeat (8) begin
         tick();
         if (done_v[0]) cnt++;
      end
      chk("abort_nodone", 0, cnt, 0);

      fork
         rand_ops(0, 1000);
         rand_ops(1, 1000);
         rand_ops(2, 1000);
         rand_ops(3, 1000);
      join
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
